video_layer_arbiter: RTL

VIDEO_LAYER_ARBITER -- requirements
Module: video_layer_arbiter

---
 rtl/video_pkg.sv | 19 +
 rtl/layer_priority_enc.sv | 31 +++
 rtl/video_layer_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared constants and types for the video layer arbiter.
package video_pkg;

  localparam int unsigned DEFAULT_NUM_LAYERS = 6;
  localparam logic [7:0]  DEFAULT_BG_COLOR   = 8'h00;

  localparam int unsigned LAYER_PLAYER  = 0;
  localparam int unsigned LAYER_PBULLET = 1;
  localparam int unsigned LAYER_ABULLET = 2;
  localparam int unsigned LAYER_ALIEN   = 3;
  localparam int unsigned LAYER_SHIELD  = 4;
  localparam int unsigned LAYER_SCORE   = 5;

  typedef enum logic [0:0] {
    S_WAIT  = 1'b0,
    S_ACCUM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/layer_priority_enc.sv
// Fixed-priority winner select (lowest index wins) plus multi-requester hit vector.
module layer_priority_enc
  import video_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS
) (
  input  logic [NUM_LAYERS-1:0]            req,
  input  logic [NUM_LAYERS-1:0]            en,
  output logic [$clog2(NUM_LAYERS+1)-1:0]  index,
  output logic                             any,
  output logic [NUM_LAYERS-1:0]            multiHit
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS-1:0] active;

  assign active = req & en;
  assign any    = |active;

  // Clearing the lowest set bit leaves something only when two or more requesters collide.
  assign multiHit = ((active & (active - NUM_LAYERS'(1))) != '0) ? active : '0;

  always_comb begin
    index = IDX_W'(NUM_LAYERS);
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (active[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/video_layer_arbiter.sv
// Per-pixel layer arbitration with per-frame collision reporting to game logic.
module video_layer_arbiter
  import video_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter logic [7:0]  BG_COLOR   = DEFAULT_BG_COLOR
) (
  input  logic                             iVGA_CLK,
  input  logic                             iRST_n,
  input  logic                             startOfFrame,
  input  logic [NUM_LAYERS-1:0]            drawReq,
  input  logic [8*NUM_LAYERS-1:0]          layerRGB,
  input  logic [NUM_LAYERS-1:0]            layerEn,
  input  logic [7:0]                       bgRGB,
  input  logic                             collAck,
  output logic [7:0]                       bgr_data_8,
  output logic [$clog2(NUM_LAYERS+1)-1:0]  layerSel,
  output logic [NUM_LAYERS-1:0]            hitFlags,
  output logic                             collValid,
  output logic                             collOverrun,
  output logic [15:0]                      frameCount
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS + 1);

  arb_state_t            state, stateNext;
  logic                  sofDly;
  logic                  sofP;
  logic [IDX_W-1:0]      winIdx;
  logic                  winAny;
  logic [NUM_LAYERS-1:0] multiHit;
  logic [7:0]            winColor;
  logic [NUM_LAYERS-1:0] hitAcc, hitAccNext, hitFlagsNext;
  logic                  collValidNext, collOverrunNext;

  layer_priority_enc #(.NUM_LAYERS(NUM_LAYERS)) u_enc (
    .req      (drawReq),
    .en       (layerEn),
    .index    (winIdx),
    .any      (winAny),
    .multiHit (multiHit)
  );

  assign sofP = startOfFrame & ~sofDly;

  always_comb begin
    winColor = bgRGB;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (winAny && (winIdx == IDX_W'(i))) winColor = layerRGB[8*i +: 8];
    end
  end

  // Next-state and collision-report bookkeeping.
  always_comb begin
    stateNext       = state;
    hitAccNext      = hitAcc;
    hitFlagsNext    = hitFlags;
    collValidNext   = collValid;
    collOverrunNext = collOverrun;
    case (state)
      S_WAIT: begin
        if (sofP) stateNext = S_ACCUM;
      end
      S_ACCUM: begin
        if (sofP) begin
          hitFlagsNext  = hitAcc | multiHit;
          hitAccNext    = '0;
          collValidNext = 1'b1;
          if (collValid && !collAck) collOverrunNext = 1'b1;
        end else begin
          hitAccNext = hitAcc | multiHit;
          if (collAck && collValid) begin
            collValidNext   = 1'b0;
            collOverrunNext = 1'b0;
          end
        end
      end
      default: stateNext = S_WAIT;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= S_WAIT;
      sofDly      <= 1'b1;
      bgr_data_8  <= BG_COLOR;
      layerSel    <= IDX_W'(NUM_LAYERS);
      hitAcc      <= '0;
      hitFlags    <= '0;
      collValid   <= 1'b0;
      collOverrun <= 1'b0;
      frameCount  <= 16'd0;
    end else begin
      state       <= stateNext;
      sofDly      <= startOfFrame;
      bgr_data_8  <= winColor;
      layerSel    <= winIdx;
      hitAcc      <= hitAccNext;
      hitFlags    <= hitFlagsNext;
      collValid   <= collValidNext;
      collOverrun <= collOverrunNext;
      if (sofP) frameCount <= frameCount + 16'd1;
    end
  end

endmodule
